// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Produces stall, flush and operand-forwarding selects from the ID, EXE and
// MEM stage status. It sequences load-use bubbles, data-memory wait states
// and redirect flushes, and it keeps saturating stall and flush counters.
module exe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_idx_i,
    input  logic [4:0]       id_rs2_idx_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_idx_i,
    input  logic             ex_reg_write_en_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       mem_rd_idx_i,
    input  logic             mem_reg_write_en_i,
    input  logic             redirection_e_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_exe_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_exe_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Down-counter value loaded when a load-use hazard is detected; the
    // detect cycle itself is the first of the LOAD_STALL_CYCLES bubbles.
    localparam logic [2:0]       LD_INIT  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Forwarding select: EXE result beats MEM/WB result, x0 never forwards,
    // and a load in EXE has no result yet so it cannot forward from EXE.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] idx,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_we
    );
        logic [1:0] sel;
        if (ex_we && (ex_rd != 5'd0) && (idx == ex_rd) && !ex_ld) begin
            sel = 2'b01;
        end else if (mem_we && (mem_rd != 5'd0) && (idx == mem_rd)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_redir_pend;
    logic              w_redir_pend_nxt;
    logic [2:0]        r_ld_cnt;
    logic [2:0]        w_ld_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_mw;
    logic              w_redir;
    logic              w_ldu;
    logic              w_stall_fe;
    logic              w_stall_be;
    logic              w_flush_id;
    logic              w_flush_exe;
    logic              w_flush_evt;
    logic [1:0]        w_fwd1;
    logic [1:0]        w_fwd2;

    assign w_mw    = dmem_req_i & ~dmem_ready_i;
    assign w_redir = redirection_e_i | r_redir_pend;
    assign w_ldu   = (r_state == ST_RUN) & ex_is_load_i & ex_reg_write_en_i &
                     (ex_rd_idx_i != 5'd0) &
                     ((id_uses_rs1_i & (id_rs1_idx_i == ex_rd_idx_i)) |
                      (id_uses_rs2_i & (id_rs2_idx_i == ex_rd_idx_i)));

    // Next-state and control decode; priority is mem-wait > redirect > load-use.
    always_comb begin
        w_state_nxt      = r_state;
        w_redir_pend_nxt = r_redir_pend;
        w_ld_cnt_nxt     = r_ld_cnt;
        w_stall_fe       = 1'b0;
        w_stall_be       = 1'b0;
        w_flush_id       = 1'b0;
        w_flush_exe      = 1'b0;
        w_flush_evt      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mw) begin
                    w_stall_fe       = 1'b1;
                    w_stall_be       = 1'b1;
                    w_redir_pend_nxt = redirection_e_i;
                    w_state_nxt      = ST_MEM_WAIT;
                end else if (w_redir) begin
                    // Redirect wins; a same-cycle load-use is wrong-path.
                    w_flush_id       = 1'b1;
                    w_flush_exe      = 1'b1;
                    w_flush_evt      = 1'b1;
                    w_redir_pend_nxt = 1'b0;
                end else if (w_ldu) begin
                    w_stall_fe   = 1'b1;
                    w_flush_exe  = 1'b1;
                    w_ld_cnt_nxt = LD_INIT;
                    if (LD_INIT == 3'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_LD_STALL;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_LD_STALL: begin
                if (w_mw) begin
                    w_stall_fe       = 1'b1;
                    w_stall_be       = 1'b1;
                    w_redir_pend_nxt = redirection_e_i;
                    w_state_nxt      = ST_MEM_WAIT;
                end else if (w_redir) begin
                    // Redirect aborts the bubble sequence.
                    w_flush_id       = 1'b1;
                    w_flush_exe      = 1'b1;
                    w_flush_evt      = 1'b1;
                    w_redir_pend_nxt = 1'b0;
                    w_ld_cnt_nxt     = 3'd0;
                    w_state_nxt      = ST_RUN;
                end else begin
                    w_stall_fe   = 1'b1;
                    w_flush_exe  = 1'b1;
                    w_ld_cnt_nxt = r_ld_cnt - 3'd1;
                    if (r_ld_cnt <= 3'd1) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_LD_STALL;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (w_mw) begin
                    w_stall_fe       = 1'b1;
                    w_stall_be       = 1'b1;
                    w_redir_pend_nxt = r_redir_pend | redirection_e_i;
                    w_state_nxt      = ST_MEM_WAIT;
                end else if (w_redir) begin
                    // First non-wait cycle: replay the redirect held during the wait.
                    w_flush_id       = 1'b1;
                    w_flush_exe      = 1'b1;
                    w_flush_evt      = 1'b1;
                    w_redir_pend_nxt = 1'b0;
                    w_state_nxt      = ST_RUN;
                end else begin
                    w_redir_pend_nxt = 1'b0;
                    w_state_nxt      = ST_RUN;
                end
            end
            default: begin
                w_redir_pend_nxt = 1'b0;
                w_ld_cnt_nxt     = 3'd0;
                w_state_nxt      = ST_RUN;
            end
        endcase
    end

    assign w_fwd1 = fwd_sel(id_rs1_idx_i, ex_rd_idx_i, ex_reg_write_en_i,
                            ex_is_load_i, mem_rd_idx_i, mem_reg_write_en_i);
    assign w_fwd2 = fwd_sel(id_rs2_idx_i, ex_rd_idx_i, ex_reg_write_en_i,
                            ex_is_load_i, mem_rd_idx_i, mem_reg_write_en_i);

    // Controls are forced quiet while reset is held.
    assign stall_if_o    = w_stall_fe  & ~reset;
    assign stall_id_o    = w_stall_fe  & ~reset;
    assign stall_exe_o   = w_stall_be  & ~reset;
    assign stall_mem_o   = w_stall_be  & ~reset;
    assign flush_id_o    = w_flush_id  & ~reset;
    assign flush_exe_o   = w_flush_exe & ~reset;
    assign fwd_rs1_sel_o = reset ? 2'b00 : w_fwd1;
    assign fwd_rs2_sel_o = reset ? 2'b00 : w_fwd2;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

    // State, pending-redirect flag and bubble down-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_redir_pend <= 1'b0;
            r_ld_cnt     <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_ld_cnt     <= w_ld_cnt_nxt;
        end
    end

    // Saturating count of cycles in which the front end is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall_if_o && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    // Saturating count of redirect flush events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt <= '0;
        end else if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end else begin
            r_flush_cnt <= r_flush_cnt;
        end
    end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl. Two instances share the stimulus:
// A (LOAD_STALL_CYCLES=1, CNT_W=32) and B (LOAD_STALL_CYCLES=3, CNT_W=2, so
// counter saturation is reachable). Each issued cycle pushes the expected
// response for one instance; the monitor pops and compares on the negedge.
module tb_exe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, ex_rd, mem_rd;
    logic       u1, u2, ex_we, ex_ld, mem_we, redir, req, rdy;

    logic        a_sif, a_sid, a_sexe, a_smem, a_fid, a_fexe;
    logic [1:0]  a_f1, a_f2;
    logic [31:0] a_sc, a_fc;
    logic        b_sif, b_sid, b_sexe, b_smem, b_fid, b_fexe;
    logic [1:0]  b_f1, b_f2;
    logic [1:0]  b_sc, b_fc;

    exe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(rst),
        .id_rs1_idx_i(rs1), .id_rs2_idx_i(rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .ex_rd_idx_i(ex_rd), .ex_reg_write_en_i(ex_we), .ex_is_load_i(ex_ld),
        .mem_rd_idx_i(mem_rd), .mem_reg_write_en_i(mem_we),
        .redirection_e_i(redir), .dmem_req_i(req), .dmem_ready_i(rdy),
        .stall_if_o(a_sif), .stall_id_o(a_sid), .stall_exe_o(a_sexe),
        .stall_mem_o(a_smem), .flush_id_o(a_fid), .flush_exe_o(a_fexe),
        .fwd_rs1_sel_o(a_f1), .fwd_rs2_sel_o(a_f2),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    exe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst),
        .id_rs1_idx_i(rs1), .id_rs2_idx_i(rs2),
        .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
        .ex_rd_idx_i(ex_rd), .ex_reg_write_en_i(ex_we), .ex_is_load_i(ex_ld),
        .mem_rd_idx_i(mem_rd), .mem_reg_write_en_i(mem_we),
        .redirection_e_i(redir), .dmem_req_i(req), .dmem_ready_i(rdy),
        .stall_if_o(b_sif), .stall_id_o(b_sid), .stall_exe_o(b_sexe),
        .stall_mem_o(b_smem), .flush_id_o(b_fid), .flush_exe_o(b_fexe),
        .fwd_rs1_sel_o(b_f1), .fwd_rs2_sel_o(b_f2),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    // Output vector: {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, fwd1, fwd2}
    localparam logic [9:0] NONE = 10'b000000_00_00;
    localparam logic [9:0] LDS  = 10'b110001_00_00;
    localparam logic [9:0] MW   = 10'b111100_00_00;
    localparam logic [9:0] RD   = 10'b000011_00_00;

    typedef struct {
        logic        sel;
        logic [9:0]  bits;
        logic        chk;
        logic [31:0] sc;
        logic [31:0] fc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    task automatic next_cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
        ex_rd = 5'd0; ex_we = 1'b0; ex_ld = 1'b0; mem_rd = 5'd0; mem_we = 1'b0;
        redir = 1'b0; req = 1'b0; rdy = 1'b0;
        cyc_n++;
    endtask

    task automatic push(input logic s, input logic [9:0] b, input logic c,
                        input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.sel = s; e.bits = b; e.chk = c; e.sc = sc; e.fc = fc; e.cyc = cyc_n;
        q.push_back(e);
    endtask

    task automatic set_ldu(input logic [4:0] r);
        ex_ld = 1'b1; ex_we = 1'b1; ex_rd = r; rs1 = r; u1 = 1'b1;
        rs2 = 5'd1; u2 = 1'b1;
    endtask

    // Monitor: compare the selected instance against the oldest expectation.
    initial begin
        exp_t        e;
        logic [9:0]  obs;
        logic [31:0] osc, ofc;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    obs = {b_sif, b_sid, b_sexe, b_smem, b_fid, b_fexe, b_f1, b_f2};
                    osc = {30'd0, b_sc};
                    ofc = {30'd0, b_fc};
                end else begin
                    obs = {a_sif, a_sid, a_sexe, a_smem, a_fid, a_fexe, a_f1, a_f2};
                    osc = a_sc;
                    ofc = a_fc;
                end
                checks++;
                if (obs !== e.bits) begin
                    failures++;
                    $display("FAIL outputs dut=%0d cyc=%0d got=%b want=%b", e.sel, e.cyc, obs, e.bits);
                end
                if (e.chk) begin
                    checks++;
                    if (osc !== e.sc) begin
                        failures++;
                        $display("FAIL stall_cnt dut=%0d cyc=%0d got=%0d want=%0d", e.sel, e.cyc, osc, e.sc);
                    end
                    checks++;
                    if (ofc !== e.fc) begin
                        failures++;
                        $display("FAIL flush_cnt dut=%0d cyc=%0d got=%0d want=%0d", e.sel, e.cyc, ofc, e.fc);
                    end
                end
            end
        end
    end

    initial begin
        // ---------------- Instance A: LOAD_STALL_CYCLES=1 ----------------
        next_cyc(); rst = 1'b1;                         push(1'b0, NONE, 1'b0, 0, 0);
        next_cyc(); rst = 1'b1;                         push(1'b0, NONE, 1'b1, 0, 0);
        // lw x5 in EXE, add x6,x5,x1 in ID
        next_cyc(); set_ldu(5'd5);                      push(1'b0, LDS,  1'b1, 0, 0);
        // load now in MEM, bubble in EXE: rs1 forwards from MEM/WB
        next_cyc(); rs1 = 5'd5; u1 = 1'b1; rs2 = 5'd1; u2 = 1'b1;
                    mem_rd = 5'd5; mem_we = 1'b1;       push(1'b0, 10'b000000_10_00, 1'b1, 1, 0);
        // redirect concurrent with load-use
        next_cyc(); set_ldu(5'd5); redir = 1'b1;        push(1'b0, RD,   1'b1, 1, 0);
        next_cyc();                                     push(1'b0, NONE, 1'b1, 1, 1);
        // four wait cycles, redirect pulse in the second one
        next_cyc(); req = 1'b1;                         push(1'b0, MW,   1'b1, 1, 1);
        next_cyc(); req = 1'b1; redir = 1'b1;           push(1'b0, MW,   1'b1, 2, 1);
        next_cyc(); req = 1'b1;                         push(1'b0, MW,   1'b1, 3, 1);
        next_cyc(); req = 1'b1;                         push(1'b0, MW,   1'b1, 4, 1);
        next_cyc(); req = 1'b1; rdy = 1'b1;             push(1'b0, RD,   1'b1, 5, 1);
        next_cyc();                                     push(1'b0, NONE, 1'b1, 5, 2);
        // EXE and MEM both write x7, ID reads x7 as rs2
        next_cyc(); ex_we = 1'b1; ex_rd = 5'd7; mem_we = 1'b1; mem_rd = 5'd7;
                    rs1 = 5'd3; rs2 = 5'd7; u2 = 1'b1;  push(1'b0, 10'b000000_00_01, 1'b1, 5, 2);
        // rd = x0 everywhere
        next_cyc(); ex_we = 1'b1; mem_we = 1'b1; u1 = 1'b1; u2 = 1'b1;
                                                        push(1'b0, NONE, 1'b1, 5, 2);
        // load in EXE never forwards from EXE; falls through to MEM match
        next_cyc(); ex_we = 1'b1; ex_ld = 1'b1; ex_rd = 5'd9; mem_we = 1'b1; mem_rd = 5'd9;
                    rs1 = 5'd9; rs2 = 5'd9;             push(1'b0, 10'b000000_10_10, 1'b1, 5, 2);
        // load-use via rs2 only
        next_cyc(); ex_we = 1'b1; ex_ld = 1'b1; ex_rd = 5'd4; rs2 = 5'd4; u2 = 1'b1;
                                                        push(1'b0, LDS,  1'b1, 5, 2);
        next_cyc();                                     push(1'b0, NONE, 1'b1, 6, 2);

        // ---------------- Instance B: LOAD_STALL_CYCLES=3, CNT_W=2 ----------------
        next_cyc(); rst = 1'b1;                         push(1'b1, NONE, 1'b0, 0, 0);
        next_cyc(); rst = 1'b1;                         push(1'b1, NONE, 1'b1, 0, 0);
        next_cyc(); set_ldu(5'd5);                      push(1'b1, LDS,  1'b1, 0, 0);
        next_cyc();                                     push(1'b1, LDS,  1'b1, 1, 0);
        next_cyc();                                     push(1'b1, LDS,  1'b1, 2, 0);
        next_cyc();                                     push(1'b1, NONE, 1'b1, 3, 0);
        // stall counter already all-ones: further stalls leave it there
        next_cyc(); set_ldu(5'd5);                      push(1'b1, LDS,  1'b1, 3, 0);
        next_cyc();                                     push(1'b1, LDS,  1'b1, 3, 0);
        // reset in the middle of LD_STALL
        next_cyc(); rst = 1'b1;                         push(1'b1, NONE, 1'b1, 3, 0);
        next_cyc();                                     push(1'b1, NONE, 1'b1, 0, 0);
        // flush counter up to saturation
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 0, 0);
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 0, 1);
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 0, 2);
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 0, 3);
        next_cyc();                                     push(1'b1, NONE, 1'b1, 0, 3);
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 0, 3);
        next_cyc();                                     push(1'b1, NONE, 1'b1, 0, 3);
        // redirect aborts an in-progress load-use bubble
        next_cyc(); set_ldu(5'd5);                      push(1'b1, LDS,  1'b1, 0, 3);
        next_cyc(); redir = 1'b1;                       push(1'b1, RD,   1'b1, 1, 3);
        next_cyc();                                     push(1'b1, NONE, 1'b1, 1, 3);

        // drain: monitor must consume every expectation within a bounded time
        for (int i = 0; i < 4; i++) begin
            if (q.size() > 0) @(negedge clk);
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
